// File: rtl/ex_mem_skid_stage_pkg.sv
// ex_mem_skid_stage_pkg: shared EX/MEM types.
// Payload bundle, ResultSrc encoding, skid states.
package ex_mem_skid_stage_pkg;

  localparam int PKG_XLEN   = 32;
  localparam int PKG_REG_AW = 5;

  typedef enum logic [1:0] {
    RES_ALU = 2'd0,
    RES_MEM = 2'd1,
    RES_PC4 = 2'd2,
    RES_IMM = 2'd3
  } result_src_t;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_TWO   = 2'd2
  } skid_state_t;

  typedef struct packed {
    logic                  reg_write;
    result_src_t           result_src;
    logic [2:0]            funct3;
    logic [PKG_XLEN-1:0]   alu_result;
    logic [PKG_REG_AW-1:0] rd;
    logic [PKG_XLEN-1:0]   rd2;
    logic [3:0]            mem_write;
    logic [PKG_XLEN-1:0]   pc_cur;
  } ex_mem_payload_t;

endpackage

// File: rtl/ex_mem_skid_stage_buffer.sv
// payload_skid_buffer: valid/ready register stage.
// DEPTH=1 plain register, DEPTH=2 registered-ready skid.
module payload_skid_buffer
  import ex_mem_skid_stage_pkg::*;
#(
  parameter type T     = ex_mem_payload_t,
  parameter int  DEPTH = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic flush,
  input  logic up_valid,
  output logic up_ready,
  input  T     up_data,
  output logic dn_valid,
  input  logic dn_ready,
  output T     dn_data
);

  T     main_q;
  logic acc;
  logic dep;

  assign acc     = up_valid && up_ready;
  assign dep     = dn_valid && dn_ready;
  assign dn_data = main_q;

  if (DEPTH == 1) begin : g_reg

    logic valid_q;

    assign dn_valid = valid_q;
    assign up_ready = !valid_q || dn_ready;

    // Valid flag: set on accept, cleared on drain or squash
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        valid_q <= 1'b0;
      end else if (flush) begin
        valid_q <= 1'b0;
      end else if (acc) begin
        valid_q <= 1'b1;
      end else if (dep) begin
        valid_q <= 1'b0;
      end
    end

    // Main payload: loads on accept, stale across squash
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        main_q <= '0;
      end else if (acc && !flush) begin
        main_q <= up_data;
      end
    end

  end else if (DEPTH == 2) begin : g_skid

    skid_state_t state_q;
    skid_state_t state_d;
    T            skid_q;
    logic        ready_q;
    logic        load_main;
    logic        load_skid;
    logic        pop_skid;

    assign dn_valid = (state_q != SKID_EMPTY);
    assign up_ready = ready_q;

    // State and ready flop; ready tracks next state
    always_ff @(posedge clk) begin
      if (!reset_n || flush) begin
        state_q <= SKID_EMPTY;
        ready_q <= 1'b1;
      end else begin
        state_q <= state_d;
        ready_q <= (state_d != SKID_TWO);
      end
    end

    // Occupancy transitions
    always_comb begin
      state_d = state_q;
      unique case (state_q)
        SKID_EMPTY: begin
          if (acc) state_d = SKID_ONE;
        end
        SKID_ONE: begin
          if (acc && !dep) state_d = SKID_TWO;
          else if (!acc && dep) state_d = SKID_EMPTY;
        end
        SKID_TWO: begin
          if (dep) state_d = SKID_ONE;
        end
        default: state_d = SKID_EMPTY;
      endcase
    end

    // Storage steering per state
    always_comb begin
      load_main = 1'b0;
      load_skid = 1'b0;
      pop_skid  = 1'b0;
      unique case (state_q)
        SKID_EMPTY: load_main = acc;
        SKID_ONE: begin
          load_main = acc && dep;
          load_skid = acc && !dep;
        end
        SKID_TWO: pop_skid = dep;
        default: ;
      endcase
    end

    // Main register: new entry or promoted skid entry
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        main_q <= '0;
      end else if (!flush) begin
        if (pop_skid) main_q <= skid_q;
        else if (load_main) main_q <= up_data;
      end
    end

    // Skid register: catches the entry arriving under stall
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        skid_q <= '0;
      end else if (load_skid && !flush) begin
        skid_q <= up_data;
      end
    end

  end else begin : g_bad_depth

    $error("payload_skid_buffer: DEPTH must be 1 or 2");

  end

endmodule

// File: rtl/ex_mem_skid_stage.sv
// ex_mem_skid_stage: EX->MEM pipeline stage.
// Packs the payload, buffers it, exposes a forwarding tap.
module ex_mem_skid_stage
  import ex_mem_skid_stage_pkg::*;
#(
  parameter int XLEN   = PKG_XLEN,
  parameter int REG_AW = PKG_REG_AW,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic              ex_reg_write,
  input  result_src_t       ex_result_src,
  input  logic [2:0]        ex_funct3,
  input  logic [XLEN-1:0]   ex_alu_result,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [XLEN-1:0]   ex_rd2,
  input  logic [3:0]        ex_mem_write,
  input  logic [XLEN-1:0]   ex_pc_cur,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_reg_write,
  output result_src_t       mem_result_src,
  output logic [2:0]        mem_funct3,
  output logic [XLEN-1:0]   mem_alu_result,
  output logic [REG_AW-1:0] mem_rd,
  output logic [XLEN-1:0]   mem_rd2,
  output logic [3:0]        mem_mem_write,
  output logic [XLEN-1:0]   mem_pc_cur,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_rd,
  output logic [XLEN-1:0]   fwd_data
);

  if (XLEN != PKG_XLEN || REG_AW != PKG_REG_AW) begin : g_bad_w
    $error("ex_mem_skid_stage: widths differ from package");
  end

  ex_mem_payload_t p_in;
  ex_mem_payload_t p_out;

  assign p_in.reg_write  = ex_reg_write;
  assign p_in.result_src = ex_result_src;
  assign p_in.funct3     = ex_funct3;
  assign p_in.alu_result = ex_alu_result;
  assign p_in.rd         = ex_rd;
  assign p_in.rd2        = ex_rd2;
  assign p_in.mem_write  = ex_mem_write;
  assign p_in.pc_cur     = ex_pc_cur;

  payload_skid_buffer #(
    .T     (ex_mem_payload_t),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk      (clk),
    .reset_n  (reset_n),
    .flush    (flush),
    .up_valid (ex_valid),
    .up_ready (ex_ready),
    .up_data  (p_in),
    .dn_valid (mem_valid),
    .dn_ready (mem_ready),
    .dn_data  (p_out)
  );

  assign mem_reg_write  = p_out.reg_write;
  assign mem_result_src = p_out.result_src;
  assign mem_funct3     = p_out.funct3;
  assign mem_alu_result = p_out.alu_result;
  assign mem_rd         = p_out.rd;
  assign mem_rd2        = p_out.rd2;
  assign mem_mem_write  = p_out.mem_write;
  assign mem_pc_cur     = p_out.pc_cur;

  assign fwd_valid = mem_valid && p_out.reg_write
                   && (p_out.rd != '0);
  assign fwd_rd    = p_out.rd;
  assign fwd_data  = p_out.alu_result;

endmodule

// File: tb/tb_ex_mem_skid_stage.sv
// tb_ex_mem_skid_stage: DEPTH=2 and DEPTH=1 side by side.
// Queue-based FIFO model, directed steps then random traffic.
module tb_ex_mem_skid_stage;
  import ex_mem_skid_stage_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset_n;
  logic            flush;
  logic            ex_valid;
  logic            mem_ready;
  ex_mem_payload_t in_p;

  logic        ex_ready_2, mem_valid_2, mem_reg_write_2;
  result_src_t mem_result_src_2;
  logic [2:0]  mem_funct3_2;
  logic [31:0] mem_alu_result_2, mem_rd2_2, mem_pc_cur_2;
  logic [4:0]  mem_rd_2, fwd_rd_2;
  logic [3:0]  mem_mem_write_2;
  logic        fwd_valid_2;
  logic [31:0] fwd_data_2;

  logic        ex_ready_1, mem_valid_1, mem_reg_write_1;
  result_src_t mem_result_src_1;
  logic [2:0]  mem_funct3_1;
  logic [31:0] mem_alu_result_1, mem_rd2_1, mem_pc_cur_1;
  logic [4:0]  mem_rd_1, fwd_rd_1;
  logic [3:0]  mem_mem_write_1;
  logic        fwd_valid_1;
  logic [31:0] fwd_data_1;

  ex_mem_payload_t out_2;
  ex_mem_payload_t out_1;

  assign out_2 = {mem_reg_write_2, mem_result_src_2,
                  mem_funct3_2, mem_alu_result_2, mem_rd_2,
                  mem_rd2_2, mem_mem_write_2, mem_pc_cur_2};
  assign out_1 = {mem_reg_write_1, mem_result_src_1,
                  mem_funct3_1, mem_alu_result_1, mem_rd_1,
                  mem_rd2_1, mem_mem_write_1, mem_pc_cur_1};

  ex_mem_skid_stage #(.DEPTH(2)) u_dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready_2),
    .ex_reg_write(in_p.reg_write),
    .ex_result_src(in_p.result_src),
    .ex_funct3(in_p.funct3),
    .ex_alu_result(in_p.alu_result),
    .ex_rd(in_p.rd), .ex_rd2(in_p.rd2),
    .ex_mem_write(in_p.mem_write),
    .ex_pc_cur(in_p.pc_cur),
    .mem_valid(mem_valid_2), .mem_ready(mem_ready),
    .mem_reg_write(mem_reg_write_2),
    .mem_result_src(mem_result_src_2),
    .mem_funct3(mem_funct3_2),
    .mem_alu_result(mem_alu_result_2),
    .mem_rd(mem_rd_2), .mem_rd2(mem_rd2_2),
    .mem_mem_write(mem_mem_write_2),
    .mem_pc_cur(mem_pc_cur_2),
    .fwd_valid(fwd_valid_2), .fwd_rd(fwd_rd_2),
    .fwd_data(fwd_data_2)
  );

  ex_mem_skid_stage #(.DEPTH(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready_1),
    .ex_reg_write(in_p.reg_write),
    .ex_result_src(in_p.result_src),
    .ex_funct3(in_p.funct3),
    .ex_alu_result(in_p.alu_result),
    .ex_rd(in_p.rd), .ex_rd2(in_p.rd2),
    .ex_mem_write(in_p.mem_write),
    .ex_pc_cur(in_p.pc_cur),
    .mem_valid(mem_valid_1), .mem_ready(mem_ready),
    .mem_reg_write(mem_reg_write_1),
    .mem_result_src(mem_result_src_1),
    .mem_funct3(mem_funct3_1),
    .mem_alu_result(mem_alu_result_1),
    .mem_rd(mem_rd_1), .mem_rd2(mem_rd2_1),
    .mem_mem_write(mem_mem_write_1),
    .mem_pc_cur(mem_pc_cur_1),
    .fwd_valid(fwd_valid_1), .fwd_rd(fwd_rd_1),
    .fwd_data(fwd_data_1)
  );

  ex_mem_payload_t q2[$];
  ex_mem_payload_t q1[$];
  bit rst_zero = 1'b0;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic ex_mem_payload_t rnd();
    ex_mem_payload_t p;
    p.reg_write  = 1'($urandom_range(0, 1));
    p.result_src = result_src_t'($urandom_range(0, 3));
    p.funct3     = 3'($urandom_range(0, 7));
    p.alu_result = $urandom;
    p.rd         = 5'($urandom_range(0, 31));
    p.rd2        = $urandom;
    p.mem_write  = 4'($urandom_range(0, 15));
    p.pc_cur     = $urandom;
    return p;
  endfunction

  function automatic ex_mem_payload_t mk(
    input logic [31:0] alu,
    input logic [4:0]  rd,
    input logic        rw);
    ex_mem_payload_t p;
    p = rnd();
    p.alu_result = alu;
    p.rd         = rd;
    p.reg_write  = rw;
    return p;
  endfunction

  task automatic check_all();
    chk("d2_ex_ready", 128'(ex_ready_2),
        128'(q2.size() < 2));
    chk("d2_mem_valid", 128'(mem_valid_2),
        128'(q2.size() > 0));
    if (q2.size() > 0) begin
      chk("d2_payload", 128'(out_2), 128'(q2[0]));
      chk("d2_fwd_valid", 128'(fwd_valid_2),
          128'(q2[0].reg_write && q2[0].rd != 0));
      chk("d2_fwd_rd", 128'(fwd_rd_2), 128'(q2[0].rd));
      chk("d2_fwd_data", 128'(fwd_data_2),
          128'(q2[0].alu_result));
    end else begin
      chk("d2_fwd_idle", 128'(fwd_valid_2), 128'(0));
    end
    chk("d1_ex_ready", 128'(ex_ready_1),
        128'(q1.size() == 0 || mem_ready));
    chk("d1_mem_valid", 128'(mem_valid_1),
        128'(q1.size() > 0));
    if (q1.size() > 0) begin
      chk("d1_payload", 128'(out_1), 128'(q1[0]));
      chk("d1_fwd_valid", 128'(fwd_valid_1),
          128'(q1[0].reg_write && q1[0].rd != 0));
    end else begin
      chk("d1_fwd_idle", 128'(fwd_valid_1), 128'(0));
    end
    if (rst_zero) begin
      chk("d2_rst_payload", 128'(out_2), 128'(0));
      chk("d1_rst_payload", 128'(out_1), 128'(0));
    end
  endtask

  task automatic step(input logic rn, input logic v,
                      input logic r, input logic f,
                      input ex_mem_payload_t p,
                      input bit do_chk);
    bit a2;
    bit a1;
    @(negedge clk);
    reset_n   = rn;
    ex_valid  = v;
    mem_ready = r;
    flush     = f;
    in_p      = p;
    #1;
    if (do_chk) check_all();
    @(posedge clk);
    if (!rn) begin
      q2.delete();
      q1.delete();
      rst_zero = 1'b1;
    end else begin
      rst_zero = 1'b0;
      if (f) begin
        q2.delete();
        q1.delete();
      end else begin
        a2 = v && (q2.size() < 2);
        a1 = v && (q1.size() == 0 || r);
        if (r && q2.size() > 0) void'(q2.pop_front());
        if (r && q1.size() > 0) void'(q1.pop_front());
        if (a2) q2.push_back(p);
        if (a1) q1.push_back(p);
      end
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    flush     = 1'b0;
    ex_valid  = 1'b1;
    mem_ready = 1'b0;
    in_p      = rnd();

    step(0, 1, 0, 0, rnd(), 0);
    step(0, 1, 1, 0, rnd(), 1);

    step(1, 1, 1, 0, mk(32'h10, 5'd1, 1'b1), 1);
    step(1, 1, 1, 0, mk(32'h20, 5'd2, 1'b1), 1);
    step(1, 1, 1, 0, mk(32'h30, 5'd3, 1'b1), 1);
    step(1, 0, 1, 0, rnd(), 1);
    step(1, 0, 1, 0, rnd(), 1);

    step(1, 1, 0, 0, mk(32'hA, 5'd4, 1'b1), 1);
    step(1, 1, 0, 0, mk(32'hB, 5'd6, 1'b1), 1);
    step(1, 1, 0, 0, mk(32'hD, 5'd7, 1'b1), 1);
    step(1, 0, 0, 0, rnd(), 1);
    step(1, 0, 1, 0, rnd(), 1);
    step(1, 0, 1, 0, rnd(), 1);
    step(1, 0, 1, 0, rnd(), 1);

    step(1, 1, 0, 0, mk(32'hA, 5'd4, 1'b1), 1);
    step(1, 1, 0, 0, mk(32'hB, 5'd6, 1'b1), 1);
    step(1, 1, 0, 1, mk(32'hC, 5'd8, 1'b1), 1);
    step(1, 0, 0, 0, rnd(), 1);
    step(1, 0, 1, 0, rnd(), 1);

    step(1, 1, 1, 0, mk(32'h1234, 5'd5, 1'b1), 1);
    step(1, 1, 1, 0, mk(32'h1234, 5'd0, 1'b1), 1);
    step(1, 0, 1, 0, rnd(), 1);
    step(1, 0, 1, 0, rnd(), 1);

    step(1, 1, 0, 0, mk(32'h55, 5'd9, 1'b0), 1);
    step(1, 0, 0, 0, rnd(), 1);
    step(1, 0, 1, 0, rnd(), 1);
    step(1, 0, 1, 0, rnd(), 1);

    step(1, 1, 0, 0, mk(32'h77, 5'd3, 1'b1), 1);
    step(0, 1, 1, 0, mk(32'h88, 5'd3, 1'b1), 1);
    step(1, 0, 1, 0, rnd(), 1);

    for (int i = 0; i < 600; i++) begin
      step(1'b1,
           1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 24) == 0),
           rnd(), 1);
    end

    step(1, 0, 1, 0, rnd(), 1);
    step(1, 0, 1, 0, rnd(), 1);
    step(1, 0, 1, 0, rnd(), 1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_mem_skid_stage.md
Name: ex_mem_skid_stage

Overview:
- Parametrised Execute-to-Memory pipeline stage with a valid/ready handshake.
- Carries the EX/MEM payload: RegWrite, ResultSrc, funct3, alu_result, rd, pc_cur, plus store data (rd2) and a byte-write mask.
- Selectable depth: DEPTH=1 is a plain registered stage; DEPTH=2 is a skid buffer so ex_ready comes straight from a flop.
- Supports synchronous flush (branch/trap squash) and exposes a forwarding tap for the hazard unit.

Parameters:
- XLEN, 32, width of alu_result, rd2 and pc_cur.
- REG_AW, 5, register-index width.
- DEPTH, 2, 1 = single register, 2 = skid buffer; any other value is an elaboration error.

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous active-low reset.
- flush  in  1  squash all held entries.
- ex_valid  in  1  Execute offers an entry.
- ex_ready  out  1  stage accepts an entry.
- ex_reg_write  in  1  RegWrite.
- ex_result_src  in  result_src_t  ResultSrc.
- ex_funct3  in  3  funct3.
- ex_alu_result  in  XLEN  ALU result.
- ex_rd  in  REG_AW  destination register.
- ex_rd2  in  XLEN  store data.
- ex_mem_write  in  4  byte-write mask.
- ex_pc_cur  in  XLEN  PC of the instruction.
- mem_valid  out  1  entry presented to Memory.
- mem_ready  in  1  Memory consumes the entry.
- mem_* outputs  out  same widths as ex_*  payload to Memory.
- fwd_valid  out  1  mem_valid && mem_reg_write && mem_rd != 0.
- fwd_rd  out  REG_AW  equals mem_rd.
- fwd_data  out  XLEN  equals mem_alu_result.

Behaviour:
- Handshake events:
  - acc = ex_valid && ex_ready.
  - dep = mem_valid && mem_ready.
  - ex_valid is never gated by ex_ready.
- Reset (reset_n=0 at a clk edge):
  - Next cycle: mem_valid=0, all mem_* payload=0, skid slot empty.
  - For DEPTH=2, ex_ready=1.
  - An entry in flight when reset asserts is discarded.
- Flush, sampled at clk:
  - Clears main and skid valids next cycle; acc in the same cycle is dropped.
  - Payload registers keep stale values.
  - Reset has priority over flush.
- mem_* outputs are driven from the main register. Zero-latency bypass is not allowed: an accepted entry appears on mem_* exactly 1 cycle after acc.
- DEPTH=1:
  - ex_ready = !mem_valid || mem_ready (combinational).
  - On acc, main loads the input and mem_valid=1.
  - On dep without acc, mem_valid=0.
- DEPTH=2 state machine, EMPTY / ONE / TWO; ex_ready = (state != TWO), registered.
  - EMPTY: acc -> ONE, main <= in.
  - ONE:
    - acc && !dep -> TWO, skid <= in.
    - acc && dep -> ONE, main <= in.
    - !acc && dep -> EMPTY.
    - else hold.
  - TWO: ex_ready=0; dep -> ONE, main <= skid; else hold.
  - mem_valid = (state != EMPTY).
- Payload is stable while mem_valid && !mem_ready.
- Ordering is strictly FIFO; no entry is lost or duplicated under any ex_valid/mem_ready pattern.
- Throughput is 1 entry/cycle when mem_ready is held 1.
- The fwd_* tap is purely combinational from the main register.

Decomposition:
- Shared package:
  - ex_mem_payload_t packed struct (reg_write, result_src, funct3, alu_result, rd, rd2, mem_write, pc_cur) using XLEN / REG_AW.
  - result_src_t (already shared).
  - Skid state enum EMPTY / ONE / TWO.
- Sub-module: payload_skid_buffer, generic on payload type and DEPTH, holds the state machine and storage. ex_mem_skid_stage wraps it and adds the forwarding tap and field packing.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles with ex_valid=1 -> mem_valid=0, mem_alu_result=0, ex_ready=1 the cycle after release.
- Streaming: mem_ready=1; push alu_result 0x10, 0x20, 0x30 on consecutive cycles -> mem_valid on cycles 1-3 with 0x10, 0x20, 0x30; ex_ready stays 1.
- Backpressure (DEPTH=2):
  - Stimulus: push 0xA then 0xB with mem_ready=0.
  - Cycle 2: ex_ready=0, mem_alu_result=0xA held stable.
  - Raise mem_ready: 0xA then 0xB drain in order; ex_ready=1 one cycle after the first dep.
- Flush: state TWO holding 0xA/0xB; assert flush with ex_valid=1 carrying 0xC -> next cycle mem_valid=0, ex_ready=1; 0xC never appears.
- Forwarding:
  - Entry rd=5, reg_write=1, alu_result=0x1234 -> fwd_valid=1, fwd_rd=5, fwd_data=0x1234.
  - Same entry with rd=0 -> fwd_valid=0.
- DEPTH=1 with mem_ready=0 and mem_valid=1 -> ex_ready=0 combinationally; it rises in the same cycle mem_ready=1.
